qkv_loader: RTL



---
 rtl/qkv_loader_pkg.sv | 10 +
 rtl/qkv_loader_if.sv | 33 +++
 rtl/qkv_row_buf.sv | 25 ++
 rtl/qkv_loader.sv | 83 ++++++++
 4 files changed

// File: rtl/qkv_loader_pkg.sv
// qkv_loader_pkg: shared state encoding, matrix select codes and counter sizing for qkv_loader.
package qkv_loader_pkg;
   typedef enum logic [1:0] {ST_LOAD, ST_FIRE, ST_WAIT} state_t;
   localparam logic [1:0] SEL_Q = 2'd0;
   localparam logic [1:0] SEL_K = 2'd1;
   localparam logic [1:0] SEL_V = 2'd2;
   function automatic int cnt_w(input int dim);
      return (3 * dim > 1) ? $clog2(3 * dim) : 1;
   endfunction
endpackage

// File: rtl/qkv_loader_if.sv
// qkv_loader_if: row-beat input stream, start/completion handshake and assembled Q/K/V matrices.
// With QKV_LOADER_LAST_CHECK_EN the stream also carries I_IN_LAST and the loader reports O_ERR.
interface qkv_loader_if #(parameter int D_W = 16, parameter int DIM = 4, parameter int HID = 3);
   logic                   I_IN_VLD;
   logic                   O_IN_RDY;
   logic [HID*D_W-1:0]     I_IN_DATA;
   logic                   O_START;
   logic [DIM*HID*D_W-1:0] O_MAT_Q;
   logic [DIM*HID*D_W-1:0] O_MAT_K;
   logic [DIM*HID*D_W-1:0] O_MAT_V;
   logic                   I_ATT_VLD;
   logic                   O_BUSY;
`ifdef QKV_LOADER_LAST_CHECK_EN
   logic                   I_IN_LAST;
   logic                   O_ERR;
`endif
   modport slave (
      input  I_IN_VLD, I_IN_DATA, I_ATT_VLD,
`ifdef QKV_LOADER_LAST_CHECK_EN
      input  I_IN_LAST,
      output O_ERR,
`endif
      output O_IN_RDY, O_START, O_MAT_Q, O_MAT_K, O_MAT_V, O_BUSY
   );
   modport master (
      output I_IN_VLD, I_IN_DATA, I_ATT_VLD,
`ifdef QKV_LOADER_LAST_CHECK_EN
      output I_IN_LAST,
      input  O_ERR,
`endif
      input  O_IN_RDY, O_START, O_MAT_Q, O_MAT_K, O_MAT_V, O_BUSY
   );
endinterface

// File: rtl/qkv_row_buf.sv
// qkv_row_buf: DIM-row register bank written one row per enabled cycle, exposed as a flat matrix.
module qkv_row_buf #(
   parameter int D_W = 16,
   parameter int DIM = 4,
   parameter int HID = 3,
   parameter int RW  = (DIM > 1) ? $clog2(DIM) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [RW-1:0]          idx,
   input  logic [HID*D_W-1:0]     wdata,
   output logic [DIM*HID*D_W-1:0] mat
);
   logic [DIM*HID*D_W-1:0] mat_q, mat_d;
   always_comb begin
      mat_d = mat_q;
      for (int r = 0; r < DIM; r++)
         if (we && idx == RW'(r)) mat_d[r*HID*D_W +: HID*D_W] = wdata;
   end
   always_ff @(posedge clk)
      if (rst) mat_q <= '0;
      else mat_q <= mat_d;
   assign mat = mat_q;
endmodule

// File: rtl/qkv_loader.sv
// qkv_loader: assembles Q, K, V from a row-per-beat stream, fires O_START, then holds until I_ATT_VLD.
// Optional QKV_LOADER_LAST_CHECK_EN validates I_IN_LAST and discards a malformed batch with an O_ERR pulse.
module qkv_loader
   import qkv_loader_pkg::*;
#(
   parameter int D_W = 16,
   parameter int DIM = 4,
   parameter int HID = 3
) (
   input logic          I_CLK,
   input logic          I_RST,
   qkv_loader_if.slave  bus
);
   localparam int CW = cnt_w(DIM);
   localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [CW-1:0] LAST = CW'(3 * DIM - 1);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic start_q, start_d, busy_q, busy_d, rdy_q, rdy_d;
   logic acc, bad, at_last;
   logic [1:0] sel;
   logic [RW-1:0] row;
   logic [DIM*HID*D_W-1:0] q_mat, k_mat, v_mat;
`ifdef QKV_LOADER_LAST_CHECK_EN
   logic err_q, err_d;
`endif
   always_comb begin
      acc = bus.I_IN_VLD && rdy_q;
      at_last = cnt_q == LAST;
`ifdef QKV_LOADER_LAST_CHECK_EN
      bad = acc && (bus.I_IN_LAST != at_last);
      err_d = bad;
`else
      bad = 1'b0;
`endif
      sel = 2'(cnt_q / CW'(DIM));
      row = RW'(cnt_q % CW'(DIM));
      cnt_d = !acc ? cnt_q : (at_last || bad) ? '0 : cnt_q + 1'b1;
      state_d = state_q == ST_LOAD ? ((acc && at_last && !bad) ? ST_FIRE : ST_LOAD)
              : state_q == ST_FIRE ? ST_WAIT
              : (bus.I_ATT_VLD ? ST_LOAD : ST_WAIT);
      start_d = state_d == ST_FIRE;
      busy_d = state_d != ST_LOAD;
      rdy_d = state_d == ST_LOAD;
   end
   // Outputs are registered from the next state so they always match state_q.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state_q <= ST_LOAD;
         cnt_q <= '0;
         start_q <= 1'b0;
         busy_q <= 1'b0;
         rdy_q <= 1'b1;
`ifdef QKV_LOADER_LAST_CHECK_EN
         err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         start_q <= start_d;
         busy_q <= busy_d;
         rdy_q <= rdy_d;
`ifdef QKV_LOADER_LAST_CHECK_EN
         err_q <= err_d;
`endif
      end
   end
   qkv_row_buf #(.D_W(D_W), .DIM(DIM), .HID(HID), .RW(RW)) u_q (
      .clk(I_CLK), .rst(I_RST), .we(acc && sel == SEL_Q), .idx(row), .wdata(bus.I_IN_DATA), .mat(q_mat));
   qkv_row_buf #(.D_W(D_W), .DIM(DIM), .HID(HID), .RW(RW)) u_k (
      .clk(I_CLK), .rst(I_RST), .we(acc && sel == SEL_K), .idx(row), .wdata(bus.I_IN_DATA), .mat(k_mat));
   qkv_row_buf #(.D_W(D_W), .DIM(DIM), .HID(HID), .RW(RW)) u_v (
      .clk(I_CLK), .rst(I_RST), .we(acc && sel == SEL_V), .idx(row), .wdata(bus.I_IN_DATA), .mat(v_mat));
   assign bus.O_IN_RDY = rdy_q;
   assign bus.O_START = start_q;
   assign bus.O_BUSY = busy_q;
   assign bus.O_MAT_Q = q_mat;
   assign bus.O_MAT_K = k_mat;
   assign bus.O_MAT_V = v_mat;
`ifdef QKV_LOADER_LAST_CHECK_EN
   assign bus.O_ERR = err_q;
`endif
endmodule
